// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter.
package vga_fb_pkg;

   localparam int unsigned H_ACT       = 640;
   localparam int unsigned V_ACT       = 480;
   localparam int unsigned FRAME_WORDS = H_ACT * V_ACT;

   // vga_ctrl drives this on pix_x / pix_y outside the active area
   localparam logic [9:0] PIX_INVALID = 10'h3FF;

   // RGB565 colours
   localparam logic [15:0] RGB_BLACK = 16'h0000;
   localparam logic [15:0] RGB_RED   = 16'hF800;
   localparam logic [15:0] RGB_WHITE = 16'hFFFF;

   // Memory-side access state: at most one SRAM access outstanding
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRd   = 2'd1,
      StWr   = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_line_fifo.sv
// Synchronous show-ahead FIFO used to prefetch display words.
module fb_line_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CntW-1:0]  count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DepthC);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop on empty is ignored; a push on full only lands if a pop frees a slot
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign do_push = push_i && !flush_i && (!full_o || do_pop);

   // Pointer and occupancy next-state; flush wins over push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, no reset needed: occupancy guards every read
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port frame-buffer SRAM between display prefetch and one pixel writer.
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int unsigned H_ACT          = vga_fb_pkg::H_ACT,
   parameter int unsigned V_ACT          = vga_fb_pkg::V_ACT,
   parameter int unsigned ADDR_W         = 19,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned LOW_WM         = 4,
   parameter logic [15:0] UNDERRUN_COLOR = vga_fb_pkg::RGB_RED
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   output logic [15:0]       pix_data,
   output logic              underrun,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   output logic              wr_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] FrameWordsC = ADDR_W'(H_ACT * V_ACT);
   localparam logic [CntW-1:0]   LowWmC      = CntW'(LOW_WM);

   fb_state_e         state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic              wr_ack_q, wr_ack_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic              drop_q, drop_d;
   logic              underrun_q, underrun_d;
   logic [15:0]       pix_data_q, pix_data_d;
   logic              y_valid_q, y_valid_d;

   logic              active, vblank_start;
   logic              rd_ok, wr_ok;
   logic              fifo_push;
   logic [15:0]       fifo_rdata;
   logic [CntW-1:0]   fifo_count;
   logic              fifo_empty, fifo_full;

   assign y_valid_d    = (pix_y != PIX_INVALID);
   assign active       = (pix_x != PIX_INVALID) && y_valid_d;
   assign vblank_start = !y_valid_d && y_valid_q;

   // No read issues on the vblank edge: fetch_addr_q is still last frame's pointer
   assign rd_ok = (fetch_addr_q < FrameWordsC) && !fifo_full && !vblank_start;
   // During the wr_ack cycle wr_req still belongs to the write that just finished
   assign wr_ok = wr_req && !wr_ack_q;

   // A read completing on the vblank edge is discarded along with the flushed FIFO
   assign fifo_push = (state_q == StRd) && mem_ack && !drop_q && !vblank_start;

   fb_line_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk_i   (vga_clk),
      .rst_ni  (sys_rst_n),
      .flush_i (vblank_start),
      .push_i  (fifo_push),
      .wdata_i (mem_rdata),
      .pop_i   (active),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Arbitration FSM, fetch pointer and drop flag next-state
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      wr_ack_d     = 1'b0;
      fetch_addr_d = fetch_addr_q;
      drop_d       = drop_q;

      unique case (state_q)
         StIdle: begin
            if (rd_ok && ((fifo_count < LowWmC) || !wr_ok)) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = fetch_addr_q;
               state_d    = StRd;
            end else if (wr_ok) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = wr_addr;
               mem_wdata_d = wr_data;
               state_d     = StWr;
            end
         end
         StRd: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = StIdle;
               if (drop_q) drop_d = 1'b0;
               else        fetch_addr_d = fetch_addr_q + ADDR_W'(1);
            end
         end
         StWr: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               wr_ack_d  = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // New frame: restart the fetch and orphan any read still in flight
      if (vblank_start) begin
         fetch_addr_d = '0;
         if ((state_q == StRd) && !mem_ack) drop_d = 1'b1;
      end
   end

   // Pixel output and sticky underrun flag next-state
   always_comb begin
      pix_data_d = RGB_BLACK;
      underrun_d = underrun_q;
      if (active) begin
         pix_data_d = fifo_empty ? UNDERRUN_COLOR : fifo_rdata;
         if (fifo_empty) underrun_d = 1'b1;
      end
      if (vblank_start) underrun_d = 1'b0;
   end

   // All block state, including the registered SRAM and display outputs
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         wr_ack_q     <= 1'b0;
         fetch_addr_q <= '0;
         drop_q       <= 1'b0;
         underrun_q   <= 1'b0;
         pix_data_q   <= '0;
         y_valid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         wr_ack_q     <= wr_ack_d;
         fetch_addr_q <= fetch_addr_d;
         drop_q       <= drop_d;
         underrun_q   <= underrun_d;
         pix_data_q   <= pix_data_d;
         y_valid_q    <= y_valid_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign wr_ack    = wr_ack_q;
   assign underrun  = underrun_q;
   assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 8x4 frame (32 words).
module tb_vga_fb_arbiter;

   localparam logic [9:0] PI = 10'h3FF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pix_x, pix_y;
   logic [15:0] pix_data;
   logic        underrun;
   logic        wr_req = 1'b0;
   logic [18:0] wr_addr = 19'h00040;
   logic [15:0] wr_data = 16'h1234;
   logic        wr_ack;
   logic        mem_req, mem_we;
   logic [18:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic        mem_ack = 1'b0;

   int checks = 0;
   int errors = 0;
   int lat = 1;
   int cnt = 0;
   int nrd_mem = 0;
   int nwr_mem = 0;
   int nwack = 0;
   bit wr_en = 1'b0;
   bit mon_en = 1'b0;

   vga_fb_arbiter #(
      .H_ACT          (8),
      .V_ACT          (4),
      .ADDR_W         (19),
      .FIFO_DEPTH     (16),
      .LOW_WM         (4),
      .UNDERRUN_COLOR (16'hF800)
   ) dut (
      .vga_clk   (clk),
      .sys_rst_n (rst_n),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_data  (pix_data),
      .underrun  (underrun),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pix(input logic [9:0] x, input logic [9:0] y);
      pix_x = x;
      pix_y = y;
   endtask

   // One pixel cycle; pix_data shows the popped word after the next rising edge
   task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic [15:0] exp,
                            input string tag);
      @(negedge clk);
      set_pix(x, y);
      @(posedge clk);
      #1;
      chk(tag, 32'(pix_data), 32'(exp));
   endtask

   // SRAM model: acks lat cycles after the request, rdata = addr[15:0]
   always @(negedge clk) begin
      if (!rst_n) begin
         mem_ack = 1'b0;
         cnt = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
         cnt = 0;
      end else if (mem_req) begin
         if (cnt >= lat) begin
            mem_ack = 1'b1;
            cnt = 0;
            if (mem_we) begin
               nwr_mem++;
               chk("wr_access_addr", 32'(mem_addr), 32'(wr_addr));
               chk("wr_access_data", 32'(mem_wdata), 32'(wr_data));
            end else begin
               nrd_mem++;
               mem_rdata = mem_addr[15:0];
               chk("rd_in_frame", 32'(mem_addr < 19'd32), 32'd1);
            end
         end else begin
            cnt++;
         end
      end else begin
         cnt = 0;
      end
   end

   // Writer: keeps requesting while enabled, new address/data after each wr_ack
   always @(negedge clk) begin
      if (wr_ack) begin
         nwack++;
         if (wr_en) begin
            wr_addr = wr_addr + 19'd1;
            wr_data = wr_data + 16'h0101;
         end else begin
            wr_req = 1'b0;
         end
      end else if (wr_en && !wr_req) begin
         wr_req = 1'b1;
      end
      if (mon_en) chk("fifo_above_lowwm", 32'(dut.fifo_count >= 5'd4), 32'd1);
   end

   initial begin
      int n, n0, nrd0, nwr0;
      rst_n = 1'b0;
      set_pix(PI, PI);
      repeat (2) @(negedge clk);
      chk("rst_pix_data", 32'(pix_data), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_fifo_count", 32'(dut.fifo_count), 32'd0);
      rst_n = 1'b1;

      // Prefetch fills the FIFO before any active pixel
      n = 0;
      while (dut.fifo_count != 5'd16 && n < 200) begin @(negedge clk); n++; end
      chk("prefill_16", 32'(dut.fifo_count), 32'd16);
      repeat (10) @(negedge clk);
      chk("full_no_req", 32'(mem_req), 32'd0);
      chk("full_count", 32'(dut.fifo_count), 32'd16);

      // Frame 1: pixels 0..31 in raster order, long horizontal blanking
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 8; x++) drive_pix(10'(x), 10'(y), 16'(y * 8 + x), "frame1_pix");
         set_pix(PI, 10'(y));
         repeat (16) @(negedge clk);
      end
      chk("frame1_underrun", 32'(underrun), 32'd0);
      repeat (10) @(negedge clk);
      chk("frame_end_empty", 32'(dut.fifo_count), 32'd0);
      chk("frame_end_no_rd", 32'(mem_req), 32'd0);

      // Fetch exhausted: the writer gets the memory
      n0 = nwack;
      wr_en = 1'b1;
      n = 0;
      while (nwack == n0 && n < 50) begin @(negedge clk); n++; end
      chk("single_wr_ack", 32'(nwack > n0), 32'd1);
      wr_en = 1'b0;
      n = 0;
      while (wr_req && n < 50) begin @(negedge clk); n++; end
      chk("writer_idle", 32'(wr_req), 32'd0);
      repeat (10) @(negedge clk);
      chk("wr_ack_vs_access", 32'(nwack), 32'(nwr_mem));

      // Frame 2: writer always requesting, ack latency 3, sparse active pixels
      @(negedge clk);
      set_pix(PI, PI);
      @(posedge clk);
      #1;
      chk("vblank2_count", 32'(dut.fifo_count), 32'd0);
      lat = 3;
      nrd0 = nrd_mem;
      nwr0 = nwr_mem;
      wr_en = 1'b1;
      n = 0;
      while (dut.fifo_count < 5'd8 && n < 400) begin @(negedge clk); n++; end
      chk("frame2_prefill", 32'(dut.fifo_count >= 5'd8), 32'd1);
      mon_en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         drive_pix(10'(i % 8), 10'(i / 8), 16'(i), "frame2_pix");
         set_pix(PI, 10'(i / 8));
         if (i == 15) mon_en = 1'b0;
         repeat (11) @(negedge clk);
      end
      chk("frame2_underrun", 32'(underrun), 32'd0);
      wr_en = 1'b0;
      n = 0;
      while (wr_req && n < 100) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      chk("frame2_wr_ack_vs_access", 32'(nwack), 32'(nwr_mem));
      chk("frame2_writes_interleaved", 32'((nwr_mem - nwr0) > 5), 32'd1);
      chk("frame2_read_count", 32'(nrd_mem - nrd0), 32'd32);

      // Slow SRAM: FIFO runs dry, underrun colour and sticky flag
      lat = 40;
      @(negedge clk);
      set_pix(PI, PI);
      repeat (20) @(negedge clk);
      chk("slow_underrun_clear", 32'(underrun), 32'd0);
      for (int x = 0; x < 8; x++) drive_pix(10'(x), 10'd0, 16'hF800, "underrun_pix");
      set_pix(PI, 10'd0);
      chk("underrun_set", 32'(underrun), 32'd1);
      n = 0;
      while (!(dut.fifo_count == 5'd1 && mem_req && !mem_we && mem_addr == 19'd1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rd1_outstanding", 32'(mem_req && mem_addr == 19'd1), 32'd1);

      // vblank with addr 1 in flight: its data must be dropped
      @(negedge clk);
      set_pix(PI, PI);
      @(posedge clk);
      #1;
      chk("vblank_underrun_clr", 32'(underrun), 32'd0);
      chk("vblank_flush", 32'(dut.fifo_count), 32'd0);
      lat = 1;
      n = 0;
      while (dut.fifo_count != 5'd16 && n < 300) begin @(negedge clk); n++; end
      chk("refill_16", 32'(dut.fifo_count), 32'd16);
      for (int x = 0; x < 8; x++) drive_pix(10'(x), 10'd0, 16'(x), "after_drop_pix");
      set_pix(PI, 10'd0);
      chk("after_drop_underrun", 32'(underrun), 32'd0);

      // Asynchronous reset in the middle of a read
      n = 0;
      while (!(mem_req && !mem_we) && n < 50) begin @(negedge clk); n++; end
      chk("rd_before_reset", 32'(mem_req && !mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_mem_req", 32'(mem_req), 32'd0);
      chk("async_rst_count", 32'(dut.fifo_count), 32'd0);
      chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_pix(PI, PI);
      n = 0;
      while (dut.fifo_count != 5'd16 && n < 200) begin @(negedge clk); n++; end
      chk("post_reset_fill", 32'(dut.fifo_count), 32'd16);
      for (int x = 0; x < 4; x++) drive_pix(10'(x), 10'd0, 16'(x), "post_reset_pix");
      set_pix(PI, 10'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
